// File: rtl/mvu_result_sink.sv
// mvu_result_sink: credit-gated issue of MVU dot-product beats with a FWFT result FIFO.
// A last beat is only issued when a FIFO slot is reserved for its result.
module mvu_result_sink #(
    parameter int PE         = 2,
    parameter int ACCU_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic                       in_zero,
    output logic                       in_ready,
    output logic                       core_en,
    output logic                       core_last,
    output logic                       core_zero,
    input  logic                       core_vld,
    input  logic [PE*ACCU_WIDTH-1:0]   core_p,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [PE*ACCU_WIDTH-1:0]   m_axis_tdata,
    output logic                       idle,
    output logic                       err_ovf
);
    localparam int DW = PE * ACCU_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [CW-1:0] count_q, count_d, inflight_q, inflight_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          err_q, err_d, ready_q, ready_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [CW:0]   used;
    logic          accept, ret, wr_en, rd_en, full;

    always_comb begin
        used          = {1'b0, count_q} + {1'b0, inflight_q};
        in_ready      = ready_q && (!in_last || used < DEPTH_W);
        accept        = in_valid && in_ready;
        core_en       = accept || inflight_q != '0;
        core_last     = accept && in_last;
        core_zero     = accept ? in_zero : core_en;
        m_axis_tvalid = count_q != '0;
        rd_en         = m_axis_tvalid && m_axis_tready;
        full          = count_q == CW'(FIFO_DEPTH);
        ret           = core_en && core_vld;
        wr_en         = ret && (!full || rd_en);
        // a return with nothing outstanding is stray and must not underflow the credit count
        inflight_d    = inflight_q + CW'(core_last) - CW'(ret && inflight_q != '0);
        count_d       = count_q + CW'(wr_en) - CW'(rd_en);
        wr_d          = wr_en ? (wr_q == LAST_PTR ? '0 : wr_q + 1'b1) : wr_q;
        rd_d          = rd_en ? (rd_q == LAST_PTR ? '0 : rd_q + 1'b1) : rd_q;
        err_d         = err_q || (ret && full && !rd_en);
        ready_d       = 1'b1;
        m_axis_tdata  = m_axis_tvalid ? mem_q[rd_q] : '0;
        idle          = inflight_q == '0 && count_q == '0;
        err_ovf       = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            inflight_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= core_p;
    end
endmodule

// File: tb/tb_mvu_result_sink.sv
// tb_mvu_result_sink: directed bench with a 5-stage enable-driven core model.
module tb_mvu_result_sink;
    localparam logic [31:0] SPUR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_last, in_zero, in_ready;
    logic        core_en, core_last, core_zero, core_vld;
    logic [31:0] core_p, m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, idle, err_ovf;
    logic        spur = 1'b0;
    int          n_chk = 0, n_fail = 0, n_acc = 0, n_iss = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  pv;
    logic [31:0] pd [5];

    always #5 clk = ~clk;

    mvu_result_sink #(.PE(2), .ACCU_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_zero(in_zero),
        .in_ready(in_ready), .core_en(core_en), .core_last(core_last), .core_zero(core_zero),
        .core_vld(core_vld), .core_p(core_p), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .idle(idle), .err_ovf(err_ovf)
    );

    function automatic logic [31:0] res_of(input int n);
        case (n)
            0: return 32'h0001_FFFB;
            1: return 32'h0002_0003;
            2: return 32'h7FFF_8000;
            3: return 32'hFFFF_0001;
            4: return 32'h1234_5678;
            5: return 32'h0064_FF9C;
            6: return 32'h8000_7FFF;
            default: return {16'hC0DE, 16'(n)};
        endcase
    endfunction

    // core: a result emerges after five enabled cycles behind its last beat
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv <= '0;
        else if (core_en) begin
            pv    <= {pv[3:0], core_last};
            pd[0] <= core_last ? res_of(n_iss) : 32'h0;
            for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
            if (core_last) n_iss <= n_iss + 1;
        end
    end
    assign core_vld = pv[4] | spur;
    assign core_p   = spur ? SPUR : pd[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic z);
        in_valid = v;
        in_last  = l;
        in_zero  = z;
        #1;
    endtask

    task automatic step();
        if (rst_n && in_valid && in_ready && in_last) exp_q.push_back(res_of(n_acc++));
        if (spur && core_en) exp_q.push_back(SPUR);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        m_axis_tready = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            while (!m_axis_tvalid && t < 20) begin step(); t++; end
            check("drain_data", m_axis_tdata, exp_q.pop_front());
            step();
        end
        m_axis_tready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; m_axis_tready = 1'b0;
        drive(1, 1, 1);
        #10;
        check("rst_in_ready", in_ready, 0);
        check("rst_core", {core_en, core_last, core_zero}, 3'b000);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_err", err_ovf, 0);
        check("rst_idle", idle, 1);
        drive(0, 1, 0);
        rst_n = 1'b1;
        step();
        check("rel_in_ready", in_ready, 1);

        // three-beat dot product followed by flush bubbles
        m_axis_tready = 1'b1;
        drive(1, 0, 1);
        check("beat_core", {core_en, core_last, core_zero}, 3'b101);
        step();
        drive(1, 0, 0);
        step();
        drive(1, 1, 0);
        check("last_ready", in_ready, 1);
        check("last_core", {core_en, core_last, core_zero}, 3'b110);
        step();
        drive(0, 0, 0);
        for (int t = 0; t < 20 && !core_vld; t++) begin
            check("flush_core", {core_en, core_last, core_zero}, 3'b101);
            step();
        end
        check("vld_seen", core_vld, 1);
        check("vld_tvalid", m_axis_tvalid, 0);
        step();
        check("s1_tvalid", m_axis_tvalid, 1);
        check("s1_data", m_axis_tdata, 32'h0001_FFFB);
        void'(exp_q.pop_front());
        check("s1_core_off", core_en, 0);
        step();
        check("s1_idle", idle, 1);

        // stray core_vld while the core is stalled is ignored
        spur = 1'b1;
        #1;
        check("spur_en", core_en, 0);
        step();
        spur = 1'b0;
        check("spur_idle", idle, 1);
        check("spur_tvalid", m_axis_tvalid, 0);

        // fill with tready low; only four last beats get credit
        m_axis_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0);
            check("fill_ready", in_ready, 1);
            step();
        end
        drive(1, 0, 0);
        check("nl_ready", in_ready, 1);
        step();
        check("nl_inflight", dut.inflight_q, 4);
        drive(1, 1, 0);
        check("blk_ready", in_ready, 0);
        for (int t = 0; t < 12; t++) step();
        check("blk_ready_late", in_ready, 0);
        check("full_count", dut.count_q, 4);
        check("full_err", err_ovf, 0);
        check("full_head", m_axis_tdata, 32'h0002_0003);

        // read and write in the same cycle while full
        spur = 1'b1;
        m_axis_tready = 1'b1;
        drive(1, 0, 0);
        check("rw_data", m_axis_tdata, exp_q.pop_front());
        step();
        spur = 1'b0;
        m_axis_tready = 1'b0;
        drive(0, 0, 0);
        check("rw_count", dut.count_q, 4);
        check("rw_err", err_ovf, 0);
        drain(4);
        drive(0, 1, 0);
        check("drained_ready", in_ready, 1);
        check("drained_idle", idle, 1);

        // upstream goes quiet with two results outstanding
        drive(1, 1, 0);
        step();
        drive(1, 1, 0);
        step();
        drive(0, 0, 0);
        check("two_inflight", dut.inflight_q, 2);
        for (int t = 0; t < 20 && dut.inflight_q != 0; t++) begin
            check("idle_flush", {core_en, core_last, core_zero}, 3'b101);
            step();
        end
        check("flush_done", core_en, 0);
        drain(2);

        // asynchronous reset with three results buffered
        for (int k = 0; k < 3; k++) begin drive(1, 1, 0); step(); end
        drive(0, 0, 0);
        for (int t = 0; t < 20 && dut.inflight_q != 0; t++) step();
        check("pre_rst_count", dut.count_q, 3);
        check("pre_rst_tvalid", m_axis_tvalid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_tdata", m_axis_tdata, 0);
        check("arst_idle", idle, 1);
        drive(1, 1, 0);
        check("arst_ready", in_ready, 0);
        exp_q.delete();
        drive(0, 1, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_idle", idle, 1);
        check("post_rst_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
